// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state/op encodings and register offsets.
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } s_sched_t;

    typedef enum logic {
        OP_TX = 1'b0,
        OP_RX = 1'b1
    } op_t;

    // Register offsets of the byte-level UART engine
    localparam logic [3:0] UART_RX_FIFO = 4'h0;
    localparam logic [3:0] UART_TX_FIFO = 4'h4;
    localparam logic [3:0] UART_STAT    = 4'h8;
    localparam logic [3:0] UART_CTRL    = 4'hc;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last+1 (mod N).
`default_nettype none

module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] index
);

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        index = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                index = IW'(idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_sched.sv
// Round-robin scheduler sharing one byte-level UART engine among NREQ requesters.
`default_nettype none

module uart_sched
    import uart_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_tx,
    input  logic [NREQ-1:0]   req_rx,
    input  logic [8*NREQ-1:0] req_tdata,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  tx_count,
    output logic [CNT_W-1:0]  rx_count,
    input  logic              u_ready,
    output logic              u_t_valid,
    output logic              u_r_valid,
    output logic [7:0]        u_t_data,
    input  logic [7:0]        u_r_data,
    input  logic              u_tx_done,
    input  logic              u_rx_done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    s_sched_t        state, state_next;
    op_t             op;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic            do_grant;
    logic            do_done;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req   (req_tx | req_rx),
        .last  (last_grant),
        .found (pick_found),
        .index (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_next;
    end

    // u_ready is only consulted in S_IDLE; the engine lowers it after the command
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (u_ready && pick_found) begin
                    do_grant   = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if ((op == OP_TX && u_tx_done) || (op == OP_RX && u_rx_done)) begin
                    do_done    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            op         <= OP_TX;
            grant_idx  <= '0;
            last_grant <= IW'(NREQ - 1);
            ack        <= '0;
            rdata      <= '0;
            busy       <= 1'b0;
            tx_count   <= '0;
            rx_count   <= '0;
            u_t_valid  <= 1'b0;
            u_r_valid  <= 1'b0;
            u_t_data   <= '0;
        end else begin
            ack       <= '0;
            u_t_valid <= 1'b0;
            u_r_valid <= 1'b0;
            if (do_grant) begin
                grant_idx <= pick_idx;
                busy      <= 1'b1;
                // TX wins when the same requester asks for both directions
                if (req_tx[pick_idx]) begin
                    op        <= OP_TX;
                    u_t_valid <= 1'b1;
                    u_t_data  <= req_tdata[int'(pick_idx)*8 +: 8];
                end else begin
                    op        <= OP_RX;
                    u_r_valid <= 1'b1;
                end
            end
            if (do_done) begin
                ack[grant_idx] <= 1'b1;
                busy           <= 1'b0;
                last_grant     <= grant_idx;
                if (op == OP_TX) begin
                    tx_count <= tx_count + 1'b1;
                end else begin
                    rx_count <= rx_count + 1'b1;
                    rdata    <= u_r_data;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/uart_sched.md
Name: uart_sched

Overview:
- Round-robin scheduler that shares the single byte-level UART engine among NREQ requesters, e.g. the core's MMIO path and the program loader.
- Each requester raises a transmit or receive request. The scheduler grants one request at a time and issues it to the UART engine as a one-cycle t_valid/r_valid pulse.
- It then waits for the engine's tx_done/rx_done pulse and returns a one-cycle ack, plus the received byte for receive operations.
- It also keeps per-direction completed-transfer counters for debug.

Parameters:
- NREQ, 2, number of requesters (1..8).
- CNT_W, 16, width of tx_count/rx_count.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req_tx  in  NREQ  per-requester transmit request; hold until ack
- req_rx  in  NREQ  per-requester receive request; hold until ack
- req_tdata  in  8*NREQ  transmit byte; requester i uses bits [8i+7:8i]
- ack  out  NREQ  one-cycle completion pulse to the granted requester
- rdata  out  8  last received byte; valid in the ack cycle of a receive
- busy  out  1  high from grant until ack
- tx_count  out  CNT_W  completed transmits, wraps
- rx_count  out  CNT_W  completed receives, wraps
- u_ready  in  1  UART engine idle
- u_t_valid  out  1  transmit command pulse to the engine
- u_r_valid  out  1  receive command pulse to the engine
- u_t_data  out  8  byte to transmit
- u_r_data  in  8  byte received from the engine
- u_tx_done  in  1  engine transmit-complete pulse
- u_rx_done  in  1  engine receive-complete pulse

Behaviour:
- Reset: clk rising edge with rstn=0 clears everything.
  - All outputs go to 0.
  - State goes to S_IDLE.
  - last_grant goes to NREQ-1, so requester 0 wins first.
  - Counters go to 0.
  - rstn is shared with the UART engine. A reset mid-transaction abandons it with no ack.
- States: S_IDLE, S_ISSUE, S_WAIT.
- S_IDLE, arbitration condition: u_ready=1 and (req_tx|req_rx) != 0.
  - Pick the first requester with a pending request, searching upward from last_grant+1 modulo NREQ.
  - Latch grant index and op: TX if req_tx[g]=1, otherwise RX. TX beats RX when the same requester raises both.
  - For TX, latch u_t_data <= req_tdata[g].
  - Set u_t_valid or u_r_valid (registered) and busy=1; go to S_ISSUE.
  - With no request or u_ready=0, stay; no outputs change.
- S_ISSUE: lasts exactly 1 cycle.
  - The valid pulse is visible in this cycle only; clear it on exit.
  - Go to S_WAIT.
  - u_ready is ignored from this point until done, because the engine drops it one cycle later.
- S_WAIT, completion:
  - Op TX: wait for u_tx_done=1.
  - Op RX: wait for u_rx_done=1 and capture rdata <= u_r_data.
  - Completing cycle: next cycle ack[g]=1 for one cycle, busy=0, last_grant <= g, and tx_count or rx_count +1 (wraps at 2^CNT_W).
  - Return to S_IDLE.
  - A done pulse of the non-matching direction is ignored.
- No timeout: an RX waits indefinitely for a byte; other requesters stall meanwhile.
- Back-to-back: the earliest next arbitration is the ack cycle itself (S_IDLE, u_ready=1).
  - A requester that drops its request in the ack cycle is not regranted.
  - Fairness: with all NREQ continuously requesting, grants rotate 0,1,…,NREQ-1.
- Request withdrawn after grant: the transaction completes and ack is still pulsed.
- u_t_data holds its value until the next TX grant.
- Latency: request at cycle 0 with u_ready=1 gives valid pulse in cycle 1. The engine's done pulse at cycle N gives ack in cycle N+1.

Decomposition:
- Package uart_pkg holds:
  - typedef enum s_sched {S_IDLE, S_ISSUE, S_WAIT};
  - typedef enum {OP_TX, OP_RX};
  - the UART register-offset constants (rx fifo 0x0, tx fifo 0x4, stat 0x8, ctrl 0xc), shared with the engine.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: request vector, last_grant.
  - Outputs: found, index.
  - Reused by future shared-resource arbiters.

Test Plan:
- Single TX: req_tx[0]=1, tdata=0x41, u_ready=1 → u_t_valid high exactly 1 cycle with u_t_data=0x41; engine tx_done 5 cycles later → ack[0] next cycle, tx_count=1, busy=0.
- Single RX: req_rx[1]=1; engine rx_done with u_r_data=0x5A → ack[1] pulse, rdata=0x5A, rx_count=1.
- Round-robin: req_tx=2'b11 held continuously, tdata0=0x10, tdata1=0x20 → issued bytes alternate 0x10,0x20,0x10,0x20; ack alternates ack[0],ack[1].
- Same-requester priority/mismatch: req_tx[0]=req_rx[0]=1 → TX issued first; a spurious u_rx_done during S_WAIT produces no ack; the subsequent u_tx_done acks.
- u_ready gating: request while u_ready=0 for 10 cycles → no valid pulse; valid appears the cycle after u_ready rises.
- Reset mid-op: rstn=0 during S_WAIT → next cycle all outputs 0 and counters 0; the later done pulse gives no ack.
